stream_demux: RTL and testbench

One-to-N stream demultiplexer with valid/ready handshake on every port: each packet arriving on the single input is routed whole to the output chosen by the select value presented on its first beat. It is the demultiplexing counterpart of the team's 2:1 `mux` and sits where one shared datapath fans out to several consumers. Each output has a one-entry register, so the block adds one cycle of latency and sustains one beat per cycle per packet. Packets with an out-of-range select are dropped and flagged.

---
 rtl/stream_demux_pkg.sv | 4 +
 rtl/stream_demux_if.sv | 19 +
 rtl/stream_demux_slot.sv | 30 +++
 rtl/stream_demux.sv | 51 +++++
 tb/tb_stream_demux.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: FSM state encoding shared by the stream demultiplexer files
package stream_demux_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUTE = 2'd1, DROP = 2'd2} state_t;
endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: one input stream and N_OUT output streams with valid/ready handshakes
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
);
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic in_last;
  logic in_valid;
  logic in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0] out_last;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;
  logic err_sel;
  modport master(output in_data, in_sel, in_last, in_valid, out_ready, input in_ready, out_data, out_last, out_valid, err_sel);
  modport slave(input in_data, in_sel, in_last, in_valid, out_ready, output in_ready, out_data, out_last, out_valid, err_sel);
endinterface

// File: rtl/stream_demux_slot.sv
// demux_slot: single-entry output register with valid/ready feeding one demux output
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic [DATA_W-1:0] in_data,
  input  logic in_last,
  input  logic out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic out_last,
  output logic out_valid,
  output logic free
);
  assign free = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_last <= 1'b0;
      out_valid <= 1'b0;
    end else if (wr) begin
      out_data <= in_data;
      out_last <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes whole packets from one input stream to the output picked by the header select
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input logic clk,
  input logic rst_n,
  stream_demux_if.slave bus
);
  state_t state, state_nx;
  logic [SEL_W-1:0] cur_sel, tgt;
  logic [N_OUT-1:0] free, wr;
  logic bad, acc, route;
  always_comb begin
    tgt = state == IDLE ? bus.in_sel : cur_sel;
    bad = state == IDLE && 32'(bus.in_sel) >= N_OUT;
    bus.in_ready = state == DROP || bad || (32'(tgt) < N_OUT && free[tgt]);
    acc = bus.in_valid && bus.in_ready;
    route = acc && state != DROP && !bad;
    state_nx = !acc ? state : bus.in_last ? IDLE : state == IDLE ? (bad ? DROP : ROUTE) : state;
  end
  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign wr[k] = route && 32'(tgt) == k;
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .wr(wr[k]),
      .in_data(bus.in_data),
      .in_last(bus.in_last),
      .out_ready(bus.out_ready[k]),
      .out_data(bus.out_data[k*DATA_W +: DATA_W]),
      .out_last(bus.out_last[k]),
      .out_valid(bus.out_valid[k]),
      .free(free[k])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_sel <= '0;
      bus.err_sel <= 1'b0;
    end else begin
      state <= state_nx;
      cur_sel <= state == IDLE && route ? bus.in_sel : cur_sel;
      bus.err_sel <= state == IDLE && acc && bad;
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed stimulus on a 4-output and a 3-output demux checked against a packet-level model
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic in_last = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] out_ready = 4'hF;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  stream_demux_if #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) b4();
  stream_demux_if #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) b3();
  assign b4.in_data = in_data;
  assign b4.in_sel = in_sel;
  assign b4.in_last = in_last;
  assign b4.in_valid = in_valid;
  assign b4.out_ready = out_ready;
  assign b3.in_data = in_data;
  assign b3.in_sel = in_sel;
  assign b3.in_last = in_last;
  assign b3.in_valid = in_valid;
  assign b3.out_ready = out_ready[2:0];
  stream_demux #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  stream_demux #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  logic [3:0] ov[2], ol[2];
  logic [31:0] od[2];
  logic ir[2], er[2];
  assign ov[0] = b4.out_valid;
  assign ov[1] = {1'b0, b3.out_valid};
  assign ol[0] = b4.out_last;
  assign ol[1] = {1'b0, b3.out_last};
  assign od[0] = b4.out_data;
  assign od[1] = {8'h00, b3.out_data};
  assign ir[0] = b4.in_ready;
  assign ir[1] = b3.in_ready;
  assign er[0] = b4.err_sel;
  assign er[1] = b3.err_sel;
  int n[2] = '{4, 3};
  bit hdr[2], drop[2], merr[2];
  int cur[2];
  bit mv[2][4], ml[2][4];
  logic [7:0] md[2][4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit exp_rdy(input int d);
    int t;
    t = hdr[d] ? int'(in_sel) : cur[d];
    if (!hdr[d] && drop[d]) return 1'b1;
    if (t >= n[d]) return 1'b1;
    return !mv[d][t] || out_ready[t];
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      hdr[d] = 1'b1;
      drop[d] = 1'b0;
      merr[d] = 1'b0;
      cur[d] = 0;
      for (int k = 0; k < 4; k++) begin
        mv[d][k] = 1'b0;
        ml[d][k] = 1'b0;
        md[d][k] = '0;
      end
    end
  endtask
  task automatic model_step(input int d);
    bit acc, go;
    int t;
    acc = in_valid && exp_rdy(d);
    go = hdr[d] ? int'(in_sel) >= n[d] : drop[d];
    t = hdr[d] ? int'(in_sel) : cur[d];
    merr[d] = acc && hdr[d] && go;
    for (int k = 0; k < n[d]; k++) if (out_ready[k]) mv[d][k] = 1'b0;
    if (acc) begin
      if (!go) begin
        mv[d][t] = 1'b1;
        md[d][t] = in_data;
        ml[d][t] = in_last;
        if (hdr[d]) cur[d] = t;
      end
      drop[d] = go;
      hdr[d] = in_last;
    end
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < n[d]; k++) begin
          chk($sformatf("valid d%0d k%0d", d, k), 32'(ov[d][k]), 32'(mv[d][k]));
          if (mv[d][k]) begin
            chk($sformatf("data d%0d k%0d", d, k), 32'(od[d][k*8 +: 8]), 32'(md[d][k]));
            chk($sformatf("last d%0d k%0d", d, k), 32'(ol[d][k]), 32'(ml[d][k]));
          end
        end
        chk($sformatf("in_ready d%0d", d), 32'(ir[d]), 32'(exp_rdy(d)));
        chk($sformatf("err_sel d%0d", d), 32'(er[d]), 32'(merr[d]));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic beat(input logic [1:0] s, input logic [7:0] dat, input logic l);
    in_valid = 1'b1;
    in_sel = s;
    in_data = dat;
    in_last = l;
  endtask
  task automatic idle();
    in_valid = 1'b0;
    in_sel = '0;
    in_data = '0;
    in_last = 1'b0;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst valid4", 32'(ov[0]), 32'h0);
    chk("rst data4", od[0], 32'h0);
    chk("rst last4", 32'(ol[0]), 32'h0);
    chk("rst err4", 32'(er[0]), 32'h0);
    chk("rst ready4", 32'(ir[0]), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    beat(2, 8'h11, 0);
    step();
    chk("p1 valid", 32'(ov[0]), 32'h4);
    chk("p1 b0", 32'(od[0][23:16]), 32'h11);
    beat(2, 8'h22, 0);
    step();
    chk("p1 b1", 32'(od[0][23:16]), 32'h22);
    beat(2, 8'h33, 1);
    step();
    chk("p1 b2", 32'(od[0][23:16]), 32'h33);
    chk("p1 last", 32'(ol[0]), 32'h4);
    idle();
    step();
    chk("p1 drained", 32'(ov[0]), 32'h0);
    beat(1, 8'hA1, 0);
    step();
    beat(3, 8'hA2, 0);
    step();
    chk("sel ignored4", 32'(ov[0]), 32'h2);
    beat(3, 8'hA3, 1);
    step();
    chk("sel ignored data4", 32'(od[0][15:8]), 32'hA3);
    chk("sel ignored3", 32'(ov[1]), 32'h2);
    idle();
    step();
    out_ready = 4'b1110;
    beat(0, 8'hB1, 0);
    step();
    beat(0, 8'hB2, 1);
    #1 chk("stall ready", 32'(ir[0]), 32'h0);
    step();
    chk("stall hold", 32'(od[0][7:0]), 32'hB1);
    chk("stall valid", 32'(ov[0][0]), 32'h1);
    out_ready = 4'hF;
    #1 chk("unstall ready", 32'(ir[0]), 32'h1);
    step();
    chk("refill data", 32'(od[0][7:0]), 32'hB2);
    chk("refill last", 32'(ol[0][0]), 32'h1);
    idle();
    step();
    beat(3, 8'hC1, 0);
    step();
    chk("drop err", 32'(er[1]), 32'h1);
    chk("drop none", 32'(ov[1]), 32'h0);
    beat(0, 8'hC2, 0);
    step();
    chk("drop err once", 32'(er[1]), 32'h0);
    chk("drop none b1", 32'(ov[1]), 32'h0);
    beat(0, 8'hC3, 1);
    step();
    chk("drop none b2", 32'(ov[1]), 32'h0);
    beat(0, 8'h5A, 1);
    step();
    chk("after drop valid", 32'(ov[1]), 32'h1);
    chk("after drop data", 32'(od[1][7:0]), 32'h5A);
    idle();
    step();
    out_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      beat(2'(i), 8'(8'hD0 + i), 1);
      #1 chk($sformatf("fill ready %0d", i), 32'(ir[0]), 32'h1);
      step();
    end
    chk("fill all", 32'(ov[0]), 32'hF);
    chk("fill data", od[0], 32'hD3D2D1D0);
    idle();
    out_ready = 4'hF;
    step();
    beat(1, 8'hE1, 0);
    step();
    beat(1, 8'hE2, 0);
    step();
    beat(1, 8'hE3, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async clr valid4", 32'(ov[0]), 32'h0);
    chk("async clr data4", od[0], 32'h0);
    chk("async clr valid3", 32'(ov[1]), 32'h0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b1;
    beat(2, 8'hF1, 1);
    step();
    chk("post rst valid4", 32'(ov[0]), 32'h4);
    chk("post rst data4", 32'(od[0][23:16]), 32'hF1);
    chk("post rst valid3", 32'(ov[1]), 32'h4);
    idle();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
